// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline types for the MEM stage and the MEM/WB register.
package pipe_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_idx_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  // Fields held in the MEM/WB register; wb_value is derived from these.
  typedef struct packed {
    logic     reg_write;
    logic     mem_to_reg;
    reg_idx_t reg_dest;
    word_t    alu_res;
    word_t    read_data;
    logic     addr_err;
  } wb_bundle_t;

  // An all-zero bundle is the bubble loaded while an access is in flight.
  localparam wb_bundle_t WB_BUBBLE = '0;

  // The wait counter needs at least one bit even when no wait cycles exist.
  function automatic int cnt_width(input int lat);
    return (lat > 0) ? $clog2(lat + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_wb_if.sv
// EXE/MEM-to-MEM bundle and the write-back bundle of the MEM/WB register.
//
// Flow control: the stage has no per-transfer valid; every cycle presents one
// instruction (nop_in marks a bubble). When stall is high the producer must
// hold every *_in signal stable; the instruction is accepted (retires) in the
// first cycle where stall is low, and its result appears on wb_* one cycle later.
interface mem_wb_if;
  import pipe_pkg::*;

  // Instruction from the EXE/MEM register
  logic       mem_to_reg_in;
  logic       reg_write_in;
  logic       mem_read_in;
  logic       mem_write_in;
  logic       nop_in;
  word_t      address_in;
  word_t      write_data_in;
  reg_idx_t   reg_dest_in;

  // Back-pressure and write-back bundle
  logic       stall;
  logic       wb_reg_write;
  logic       wb_mem_to_reg;
  reg_idx_t   wb_reg_dest;
  word_t      wb_alu_res;
  word_t      wb_read_data;
  word_t      wb_value;
  logic       addr_err;

  // Debug view of the access FSM
  mem_state_e state_dbg;

  // Upstream side: drives the instruction, observes stall and write-back.
  modport master (
    output mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in, nop_in,
           address_in, write_data_in, reg_dest_in,
    input  stall, wb_reg_write, wb_mem_to_reg, wb_reg_dest, wb_alu_res,
           wb_read_data, wb_value, addr_err, state_dbg
  );

  // Stage side.
  modport slave (
    input  mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in, nop_in,
           address_in, write_data_in, reg_dest_in,
    output stall, wb_reg_write, wb_mem_to_reg, wb_reg_dest, wb_alu_res,
           wb_read_data, wb_value, addr_err, state_dbg
  );

endinterface

// File: rtl/mem_wb_stage_data_mem.sv
// Word-addressed data memory: synchronous write, asynchronous read.
// Contents are never cleared by reset.
module data_mem
  import pipe_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  word_t            wdata,
  input  logic [IDX_W-1:0] ridx,
  output word_t            rdata
);

  word_t mem [DEPTH];

  // Commit a store at the clock edge that ends its retire cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  // Read is combinational, so a load sees a store committed one edge earlier.
  assign rdata = mem[ridx];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB pipeline register. Performs lw/sw against the data
// memory with MEM_LATENCY extra wait cycles, stalls upstream while an access
// is in flight, and registers the write-back bundle for the register file.
module mem_wb_stage
  import pipe_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int MEM_LATENCY = 0
) (
  input  logic     clk,
  input  logic     rst,
  mem_wb_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(MEM_LATENCY);

  // Counter load value on entering WAIT: the IDLE cycle already counts as one
  // stall cycle, so WAIT holds MEM_LATENCY-1 more before retiring.
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic             stall_int;

  logic             access;
  logic             is_store;
  logic             misaligned;
  logic [IDX_W-1:0] mem_idx;
  logic             mem_we;
  word_t            mem_rdata;

  wb_bundle_t       wb_q, wb_d;

  // Access decode: a bubble never touches memory; a combined read+write is a store.
  always_comb begin
    access     = (bus.mem_read_in | bus.mem_write_in) & ~bus.nop_in;
    is_store   = bus.mem_write_in;
    misaligned = (bus.address_in[1:0] != 2'b00);
    mem_idx    = bus.address_in[IDX_W+1:2];
  end

  // Access FSM: decides whether the current instruction retires this cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retire    = 1'b1;
    stall_int = 1'b0;
    if (MEM_LATENCY > 0) begin
      case (state_q)
        ST_IDLE: begin
          if (access) begin
            stall_int = 1'b1;
            retire    = 1'b0;
            cnt_d     = CNT_INIT;
            state_d   = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q != '0) begin
            stall_int = 1'b1;
            retire    = 1'b0;
            cnt_d     = cnt_q - 1'b1;
          end else begin
            state_d   = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // A store commits once, on its retire edge, unless misaligned or under reset.
  assign mem_we = retire & access & is_store & ~misaligned & ~rst;

  data_mem #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_data_mem (
    .clk   (clk),
    .we    (mem_we),
    .widx  (mem_idx),
    .wdata (bus.write_data_in),
    .ridx  (mem_idx),
    .rdata (mem_rdata)
  );

  // Next MEM/WB contents: a bubble while stalled, the retiring instruction otherwise.
  always_comb begin
    wb_d = WB_BUBBLE;
    if (retire) begin
      wb_d.reg_write  = bus.reg_write_in & ~bus.nop_in &
                        (bus.reg_dest_in != '0) &
                        ~(access & (is_store | misaligned));
      wb_d.mem_to_reg = bus.mem_to_reg_in & ~bus.nop_in;
      wb_d.reg_dest   = bus.reg_dest_in;
      wb_d.alu_res    = bus.address_in;
      wb_d.read_data  = (access & ~misaligned) ? mem_rdata : '0;
      wb_d.addr_err   = access & misaligned;
    end
  end

  // FSM, wait counter and MEM/WB register; reset discards any in-flight access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wb_q    <= WB_BUBBLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
    end
  end

  // Outputs: stall is forced low during reset; wb_value selects the write-back source.
  always_comb begin
    bus.stall         = stall_int & ~rst;
    bus.wb_reg_write  = wb_q.reg_write;
    bus.wb_mem_to_reg = wb_q.mem_to_reg;
    bus.wb_reg_dest   = wb_q.reg_dest;
    bus.wb_alu_res    = wb_q.alu_res;
    bus.wb_read_data  = wb_q.read_data;
    bus.wb_value      = wb_q.mem_to_reg ? wb_q.read_data : wb_q.alu_res;
    bus.addr_err      = wb_q.addr_err;
    bus.state_dbg     = mem_state_e'(state_q);
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: three instances (MEM_LATENCY 0, 2, 3) exercised from
// a vector table, a short random store/load run and a reset-in-flight sequence.
module tb_mem_wb_stage;
  import pipe_pkg::*;

  localparam int WB_W = 104;

  typedef struct packed {
    logic        rd, wr, m2r, rw, nop;
    logic [31:0] addr, wdata;
    logic [4:0]  dest;
  } in_t;

  typedef struct {
    int          dut;
    string       name;
    in_t         in;
    logic        e_rw;
    logic [31:0] e_rdata;
    logic        rd_chk;
    logic        e_err;
    int          e_stall;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  in_t             in_v    [3];
  logic [WB_W-1:0] act_v   [3];
  logic            stall_v [3];
  logic [0:0]      st_v    [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_wb_if bus ();
    assign bus.mem_read_in   = in_v[g].rd;
    assign bus.mem_write_in  = in_v[g].wr;
    assign bus.mem_to_reg_in = in_v[g].m2r;
    assign bus.reg_write_in  = in_v[g].rw;
    assign bus.nop_in        = in_v[g].nop;
    assign bus.address_in    = in_v[g].addr;
    assign bus.write_data_in = in_v[g].wdata;
    assign bus.reg_dest_in   = in_v[g].dest;
    assign act_v[g] = {bus.wb_reg_write, bus.wb_mem_to_reg, bus.wb_reg_dest,
                       bus.wb_alu_res, bus.wb_read_data, bus.wb_value, bus.addr_err};
    assign stall_v[g] = bus.stall;
    assign st_v[g]    = bus.state_dbg;
    mem_wb_stage #(
      .DEPTH       (1024),
      .MEM_LATENCY ((g == 0) ? 0 : (g == 1) ? 2 : 3)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
  end

  // ---------------- scoreboard ----------------
  logic [WB_W-1:0] exp_q  [$];
  logic [WB_W-1:0] mask_q [$];
  string           name_q [$];
  int              dut_q  [$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string nm, input logic [WB_W-1:0] act, input logic [WB_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [WB_W-1:0] exp_of(input vec_t v);
    logic        m2r;
    logic [31:0] val;
    m2r = v.in.m2r & ~v.in.nop;
    val = m2r ? v.e_rdata : v.in.addr;
    return {v.e_rw, m2r, v.in.dest, v.in.addr, v.e_rdata, val, v.e_err};
  endfunction

  function automatic logic [WB_W-1:0] mask_of(input vec_t v);
    logic [WB_W-1:0] m;
    m = '1;
    if (!v.rd_chk) m[64:33] = '0;
    return m;
  endfunction

  task automatic check_pending();
    logic [WB_W-1:0] e, m;
    string           nm;
    int              d;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      m  = mask_q.pop_front();
      nm = name_q.pop_front();
      d  = dut_q.pop_front();
      check(nm, act_v[d] & m, e & m);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Entered and left at posedge+1; drives one instruction until it retires.
  task automatic issue(input vec_t v);
    int stalls;
    bit done;
    in_v[v.dut] = v.in;
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (c == 0) check_pending();
      else check({"bubble ", v.name}, act_v[v.dut], '0);
      if (stall_v[v.dut]) stalls++;
      else done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout %s: stall still high after 20 cycles", v.name);
    end
    check({"stall_cycles ", v.name}, WB_W'(stalls), WB_W'(v.e_stall));
    exp_q.push_back(exp_of(v));
    mask_q.push_back(mask_of(v));
    name_q.push_back(v.name);
    dut_q.push_back(v.dut);
    in_v[v.dut] = '0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    check_pending();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input int dut, input string name,
                              input logic rd, input logic wr, input logic m2r,
                              input logic rw, input logic nop,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [4:0] dest, input logic e_rw,
                              input logic [31:0] e_rdata, input logic rd_chk,
                              input logic e_err, input int e_stall);
    vec_t v;
    v.dut     = dut;
    v.name    = name;
    v.in      = '{rd: rd, wr: wr, m2r: m2r, rw: rw, nop: nop,
                  addr: addr, wdata: wdata, dest: dest};
    v.e_rw    = e_rw;
    v.e_rdata = e_rdata;
    v.rd_chk  = rd_chk;
    v.e_err   = e_err;
    v.e_stall = e_stall;
    return v;
  endfunction

  // ---------------- test ----------------
  vec_t tbl [$];

  initial begin
    //          dut name          rd wr m2r rw nop addr         wdata        dest e_rw e_rdata      chk err stall
    tbl.push_back(mk(0, "l0_sw40",     0, 1, 0, 0, 0, 32'h40,   32'h12345678, 0, 0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, "l0_lw40_raw", 1, 0, 1, 1, 0, 32'h40,   32'h0,        5, 1, 32'h12345678, 1, 0, 0));
    tbl.push_back(mk(0, "l0_rdwr40",   1, 1, 0, 1, 0, 32'h40,   32'h11112222, 6, 0, 32'h12345678, 1, 0, 0));
    tbl.push_back(mk(0, "l0_lw40_new", 1, 0, 1, 1, 0, 32'h40,   32'h0,        6, 1, 32'h11112222, 1, 0, 0));
    tbl.push_back(mk(1, "l2_sw8",      0, 1, 0, 0, 0, 32'h8,    32'hCAFEF00D, 0, 0, 32'h0,        0, 0, 2));
    tbl.push_back(mk(1, "l2_lw8",      1, 0, 1, 1, 0, 32'h8,    32'h0,        3, 1, 32'hCAFEF00D, 1, 0, 2));
    tbl.push_back(mk(1, "l2_add",      0, 0, 0, 1, 0, 32'h7,    32'h0,        9, 1, 32'h0,        0, 0, 0));
    tbl.push_back(mk(1, "l2_sw40",     0, 1, 0, 0, 0, 32'h40,   32'h55AA55AA, 0, 0, 32'h0,        0, 0, 2));
    tbl.push_back(mk(1, "l2_lw42_mis", 1, 0, 1, 1, 0, 32'h42,   32'h0,        4, 0, 32'h0,        1, 1, 2));
    tbl.push_back(mk(1, "l2_sw42_mis", 0, 1, 0, 0, 0, 32'h42,   32'hFFFFFFFF, 0, 0, 32'h0,        1, 1, 2));
    tbl.push_back(mk(1, "l2_lw40_kept",1, 0, 1, 1, 0, 32'h40,   32'h0,        4, 1, 32'h55AA55AA, 1, 0, 2));
    tbl.push_back(mk(1, "l2_sw1000",   0, 1, 0, 0, 0, 32'h1000, 32'hA5A5A5A5, 0, 0, 32'h0,        0, 0, 2));
    tbl.push_back(mk(1, "l2_lw0_wrap", 1, 0, 1, 1, 0, 32'h0,    32'h0,        2, 1, 32'hA5A5A5A5, 1, 0, 2));
    tbl.push_back(mk(1, "l2_nop",      1, 0, 1, 1, 1, 32'h20,   32'h0,        7, 0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(1, "l2_rd0",      0, 0, 0, 1, 0, 32'h3,    32'h0,        0, 0, 32'h0,        0, 0, 0));

    rst = 1'b1;
    for (int d = 0; d < 3; d++) in_v[d] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_wb dut%0d", d), act_v[d], '0);
      check($sformatf("reset_stall dut%0d", d), WB_W'(stall_v[d]), '0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (tbl[i]) issue(tbl[i]);
    idle_cycle();

    // Random aligned store/load pairs on the latency-2 instance.
    for (int k = 0; k < 4; k++) begin
      logic [31:0] a, dat;
      logic [4:0]  r;
      a   = 32'($urandom_range(64, 127)) << 2;
      dat = $urandom;
      r   = 5'($urandom_range(1, 31));
      issue(mk(1, $sformatf("rnd_sw%0d", k), 0, 1, 0, 0, 0, a, dat, 0, 0, 32'h0, 0, 0, 2));
      issue(mk(1, $sformatf("rnd_lw%0d", k), 1, 0, 1, 1, 0, a, 32'h0, r, 1, dat, 1, 0, 2));
    end
    idle_cycle();

    // Reset in the middle of a latency-3 store.
    issue(mk(2, "l3_pre_sw10", 0, 1, 0, 0, 0, 32'h10, 32'h0, 0, 0, 32'h0, 0, 0, 3));
    in_v[2] = '{rd: 1'b0, wr: 1'b1, m2r: 1'b0, rw: 1'b0, nop: 1'b0,
                addr: 32'h10, wdata: 32'hDEADBEEF, dest: 5'd0};
    @(negedge clk);
    check_pending();
    check("l3_stall_first", WB_W'(stall_v[2]), WB_W'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("l3_stall_in_rst", WB_W'(stall_v[2]), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_v[2] = '0;
    @(negedge clk);
    check("l3_wb_after_rst", act_v[2], '0);
    check("l3_state_after_rst", WB_W'(st_v[2]), WB_W'(IDLE));
    @(posedge clk);
    #1;
    issue(mk(2, "l3_lw10_old", 1, 0, 1, 1, 0, 32'h10, 32'h0, 1, 1, 32'h0, 1, 0, 3));
    idle_cycle();

    check("queue_drained", WB_W'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
